// File: rtl/diff_in_scan_ctrl.sv
// 8-channel sync + periodic sample + debounce scanner with bus regs; edge-event flags when DIFI_EDGE_EVENT_EN is defined.
// Latency: sample -> diff_in_debounced 1 cycle, reads registered 1 cycle; no backpressure, every strobe is accepted.
module diff_in_scan_ctrl #(
  parameter logic [7:0] ADDR_CTRL   = 8'h60,
  parameter logic [7:0] ADDR_PERIOD = 8'h61,
  parameter logic [7:0] ADDR_STATE  = 8'h62,
  parameter logic [7:0] ADDR_EVENT  = 8'h63
) (
  input  logic        xclk,
  input  logic        reset,
  input  logic        write_qualified,
  input  logic        read_qualified,
  input  logic [7:0]  ab,
  input  logic [15:0] db_in,
  input  logic [7:0]  diff_in,
  output logic [15:0] db_out_DISC,
  output logic        data_from_DISC_avail,
  output logic [7:0]  diff_in_debounced,
  output logic        sample_strobe,
  output logic        event_irq
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_COUNT  = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;

  logic [1:0]      state;
  logic            en;
  logic [3:0]      db_cnt;
  logic [15:0]     period;
  logic [15:0]     prescaler;
  logic [7:0]      sync1;
  logic [7:0]      sync2;
  logic [7:0][3:0] chan_cnt;
  logic [7:0][3:0] cnt_next;
  logic [7:0]      deb_next;
  logic [3:0]      thr;
  logic [4:0]      inc;
  logic [15:0]     ev_dat;
  logic [15:0]     rd_dat;
  logic            rd_hit;
  logic            wr_ctrl;
  logic            wr_period;

  assign wr_ctrl       = write_qualified && (ab == ADDR_CTRL);
  assign wr_period     = write_qualified && (ab == ADDR_PERIOD);
  assign sample_strobe = (state == ST_SAMPLE);

  always_ff @(posedge xclk) begin
    if (!reset) begin
      sync1 <= 8'h00;
      sync2 <= 8'h00;
    end else begin
      sync1 <= diff_in;
      sync2 <= sync1;
    end
  end

  // Counter counts consecutive disagreeing samples; a zero threshold behaves as one.
  always_comb begin
    deb_next = diff_in_debounced;
    cnt_next = chan_cnt;
    thr      = (db_cnt == 4'd0) ? 4'd1 : db_cnt;
    inc      = 5'd0;
    if (state == ST_SAMPLE) begin
      for (int i = 0; i < 8; i++) begin
        inc = {1'b0, chan_cnt[i]} + 5'd1;
        if (sync2[i] == diff_in_debounced[i]) begin
          cnt_next[i] = 4'd0;
        end else if (inc >= {1'b0, thr}) begin
          deb_next[i] = sync2[i];
          cnt_next[i] = 4'd0;
        end else begin
          cnt_next[i] = inc[3:0];
        end
      end
    end
  end

  always_ff @(posedge xclk) begin
    if (!reset) begin
      state             <= ST_IDLE;
      en                <= 1'b0;
      db_cnt            <= 4'd0;
      period            <= 16'd0;
      prescaler         <= 16'd0;
      chan_cnt          <= '0;
      diff_in_debounced <= 8'h00;
    end else begin
      if (wr_ctrl) begin
        en     <= db_in[0];
        db_cnt <= db_in[7:4];
      end
      if (wr_period) begin
        period <= db_in;
      end
      diff_in_debounced <= deb_next;
      chan_cnt          <= cnt_next;
      if (wr_ctrl && !db_in[0]) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (en) begin
              state     <= ST_COUNT;
              prescaler <= period;
            end
          end
          // COUNT lasts PERIOD cycles so samples land PERIOD+1 apart.
          ST_COUNT: begin
            if (prescaler <= 16'd1) begin
              state     <= ST_SAMPLE;
              prescaler <= 16'd0;
            end else begin
              prescaler <= prescaler - 16'd1;
            end
          end
          ST_SAMPLE: begin
            if (period != 16'd0) begin
              state     <= ST_COUNT;
              prescaler <= period;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef DIFI_EDGE_EVENT_EN
  logic [7:0] ev_rise;
  logic [7:0] ev_fall;
  logic [7:0] rise_nx;
  logic [7:0] fall_nx;

  // A set from a debounced transition wins over a same-cycle write-1 clear.
  always_comb begin
    rise_nx = ev_rise;
    fall_nx = ev_fall;
    if (write_qualified && (ab == ADDR_EVENT)) begin
      rise_nx = ev_rise & ~db_in[15:8];
      fall_nx = ev_fall & ~db_in[7:0];
    end
    rise_nx = rise_nx | (deb_next & ~diff_in_debounced);
    fall_nx = fall_nx | (~deb_next & diff_in_debounced);
  end

  always_ff @(posedge xclk) begin
    if (!reset) begin
      ev_rise   <= 8'h00;
      ev_fall   <= 8'h00;
      event_irq <= 1'b0;
    end else begin
      ev_rise   <= rise_nx;
      ev_fall   <= fall_nx;
      event_irq <= |{rise_nx, fall_nx};
    end
  end

  assign ev_dat = {ev_rise, ev_fall};
`else
  assign ev_dat    = 16'h0000;
  assign event_irq = 1'b0;
`endif

  always_comb begin
    rd_dat = 16'hFFFF;
    rd_hit = 1'b1;
    case (ab)
      ADDR_CTRL:   rd_dat = {8'h00, db_cnt, 3'b000, en};
      ADDR_PERIOD: rd_dat = period;
      ADDR_STATE:  rd_dat = {8'h00, diff_in_debounced};
      ADDR_EVENT:  rd_dat = ev_dat;
      default:     rd_hit = 1'b0;
    endcase
  end

  always_ff @(posedge xclk) begin
    if (!reset) begin
      db_out_DISC          <= 16'h0000;
      data_from_DISC_avail <= 1'b0;
    end else if (read_qualified) begin
      db_out_DISC          <= rd_dat;
      data_from_DISC_avail <= rd_hit;
    end
  end

endmodule

// File: tb/tb_diff_in_scan_ctrl.sv
// Bench for diff_in_scan_ctrl: directed scenarios plus randomized debounce traffic checked against a sample-level model.
// Inputs change 1 time unit after the rising edge; outputs are observed at the falling edge or just after the rising edge.
module tb_diff_in_scan_ctrl;

  localparam logic [7:0] A_CTRL = 8'h60;
  localparam logic [7:0] A_PER  = 8'h61;
  localparam logic [7:0] A_ST   = 8'h62;
  localparam logic [7:0] A_EV   = 8'h63;
`ifdef DIFI_EDGE_EVENT_EN
  localparam bit EV_ON = 1'b1;
`else
  localparam bit EV_ON = 1'b0;
`endif

  logic        xclk = 1'b0;
  logic        reset = 1'b0;
  logic        write_qualified = 1'b0;
  logic        read_qualified = 1'b0;
  logic [7:0]  ab = 8'h00;
  logic [15:0] db_in = 16'h0000;
  logic [7:0]  diff_in = 8'h00;
  logic [15:0] db_out_DISC;
  logic        data_from_DISC_avail;
  logic [7:0]  diff_in_debounced;
  logic        sample_strobe;
  logic        event_irq;

  diff_in_scan_ctrl dut (
    .xclk(xclk), .reset(reset), .write_qualified(write_qualified), .read_qualified(read_qualified),
    .ab(ab), .db_in(db_in), .diff_in(diff_in), .db_out_DISC(db_out_DISC),
    .data_from_DISC_avail(data_from_DISC_avail), .diff_in_debounced(diff_in_debounced),
    .sample_strobe(sample_strobe), .event_irq(event_irq)
  );

  always #5 xclk = ~xclk;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;

  // Reference state: register contents, last three input values, per-channel disagreement runs.
  logic        m_en;
  logic [3:0]  m_dbcnt;
  logic [15:0] m_period;
  logic [7:0]  m_deb, m_rise, m_fall;
  logic        m_irq;
  int          m_cnt[8];
  logic [7:0]  h0, h1, h2;
  logic [15:0] m_dout;
  logic        m_avail;
  logic        strobe_q;

  task automatic tick();
    logic [7:0] smp, nd;
    int thr;
    @(negedge xclk);
    cyc++;
    h2 = h1; h1 = h0; h0 = diff_in;
    strobe_q = sample_strobe;
    if (!reset) begin
      m_en = 0; m_dbcnt = 0; m_period = 0; m_deb = 0; m_rise = 0; m_fall = 0;
      m_dout = 0; m_avail = 0; h0 = 0; h1 = 0;
      for (int i = 0; i < 8; i++) m_cnt[i] = 0;
    end else begin
      if (read_qualified) begin
        m_avail = 1;
        case (ab)
          A_CTRL:  m_dout = {8'h00, m_dbcnt, 3'b000, m_en};
          A_PER:   m_dout = m_period;
          A_ST:    m_dout = {8'h00, m_deb};
          A_EV:    m_dout = EV_ON ? {m_rise, m_fall} : 16'h0000;
          default: begin m_dout = 16'hFFFF; m_avail = 0; end
        endcase
      end
      nd = m_deb;
      if (sample_strobe) begin
        smp = h2;
        thr = (m_dbcnt == 0) ? 1 : int'(m_dbcnt);
        for (int i = 0; i < 8; i++) begin
          if (smp[i] == m_deb[i]) m_cnt[i] = 0;
          else begin
            m_cnt[i]++;
            if (m_cnt[i] >= thr) begin nd[i] = smp[i]; m_cnt[i] = 0; end
          end
        end
      end
      if (EV_ON && write_qualified && ab == A_EV) begin
        m_rise = m_rise & ~db_in[15:8];
        m_fall = m_fall & ~db_in[7:0];
      end
      if (EV_ON) begin
        m_rise = m_rise | (nd & ~m_deb);
        m_fall = m_fall | (~nd & m_deb);
      end
      m_deb = nd;
      if (write_qualified && ab == A_CTRL) begin m_en = db_in[0]; m_dbcnt = db_in[7:4]; end
      if (write_qualified && ab == A_PER) m_period = db_in;
    end
    m_irq = |{m_rise, m_fall};
    @(posedge xclk); #1;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [15:0] d);
    ab = a; db_in = d; write_qualified = 1'b1;
    tick();
    write_qualified = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a);
    ab = a; read_qualified = 1'b1;
    tick();
    read_qualified = 1'b0;
  endtask

  task automatic test_reset();
    int ns = 0;
    reset = 1'b0; diff_in = 8'($urandom);
    write_qualified = 1'b1; read_qualified = 1'b1; ab = A_CTRL; db_in = 16'h0011;
    repeat (3) tick();
    write_qualified = 1'b0; read_qualified = 1'b0; reset = 1'b1;
    nvec++; if (db_out_DISC !== 16'h0000) begin nerr++; $display("FAIL reset_dout got=%h exp=0000", db_out_DISC); end
    nvec++; if (data_from_DISC_avail !== 1'b0) begin nerr++; $display("FAIL reset_avail got=%b exp=0", data_from_DISC_avail); end
    nvec++; if (diff_in_debounced !== 8'h00) begin nerr++; $display("FAIL reset_deb got=%h exp=00", diff_in_debounced); end
    nvec++; if (sample_strobe !== 1'b0) begin nerr++; $display("FAIL reset_strobe got=%b exp=0", sample_strobe); end
    nvec++; if (event_irq !== 1'b0) begin nerr++; $display("FAIL reset_irq got=%b exp=0", event_irq); end
    for (int k = 0; k < 10; k++) begin tick(); if (strobe_q) ns++; end
    nvec++; if (ns !== 0) begin nerr++; $display("FAIL reset_idle_strobes got=%0d exp=0", ns); end
  endtask

  task automatic test_period();
    int last, n, p;
    bus_write(A_PER, 16'd4);
    bus_write(A_CTRL, 16'h0011);
    last = -1; n = 0;
    for (int k = 0; k < 80 && n < 8; k++) begin
      tick();
      if (strobe_q) begin
        if (last >= 0) begin
          n++; nvec++;
          if (cyc - last !== 5) begin nerr++; $display("FAIL period4_gap got=%0d exp=5", cyc - last); end
        end
        last = cyc;
      end
    end
    nvec++; if (n !== 8) begin nerr++; $display("FAIL period4_timeout got=%0d gaps exp=8", n); end
    bus_write(A_PER, 16'd0);
    repeat (8) tick();
    for (int k = 0; k < 10; k++) begin
      tick();
      nvec++; if (strobe_q !== 1'b1) begin nerr++; $display("FAIL period0_strobe got=%b exp=1", strobe_q); end
    end
    for (int r = 0; r < 3; r++) begin
      p = $urandom_range(1, 7);
      bus_write(A_PER, 16'(p));
      repeat (20) tick();
      last = -1; n = 0;
      for (int k = 0; k < 60 && n < 4; k++) begin
        tick();
        if (strobe_q) begin
          if (last >= 0) begin
            n++; nvec++;
            if (cyc - last !== p + 1) begin nerr++; $display("FAIL periodr_gap got=%0d exp=%0d", cyc - last, p + 1); end
          end
          last = cyc;
        end
      end
      nvec++; if (n !== 4) begin nerr++; $display("FAIL periodr_timeout got=%0d gaps exp=4", n); end
    end
  endtask

  task automatic test_debounce();
    int sc = 0;
    bus_write(A_PER, 16'd2);
    bus_write(A_CTRL, 16'h0031);
    diff_in = 8'h00;
    repeat (24) tick();
    nvec++; if (diff_in_debounced !== 8'h00) begin nerr++; $display("FAIL deb_settle got=%h exp=00", diff_in_debounced); end
    diff_in = 8'h04;
    tick(); tick();
    for (int k = 0; k < 40 && sc < 3; k++) begin
      tick();
      if (strobe_q) sc++;
      nvec++;
      if (diff_in_debounced !== ((sc >= 3) ? 8'h04 : 8'h00)) begin
        nerr++; $display("FAIL deb_third_strobe got=%h exp=%h after %0d strobes", diff_in_debounced, (sc >= 3) ? 8'h04 : 8'h00, sc);
      end
    end
    nvec++; if (sc !== 3) begin nerr++; $display("FAIL deb_timeout got=%0d strobes exp=3", sc); end
    diff_in = 8'h00;
    repeat (5) tick();
    diff_in = 8'h04;
    repeat (15) tick();
    nvec++; if (diff_in_debounced !== 8'h04) begin nerr++; $display("FAIL deb_glitch got=%h exp=04", diff_in_debounced); end
    for (int k = 0; k < 400; k++) begin
      if (k % 50 == 0) begin
        bus_write(A_PER, 16'($urandom_range(0, 3)));
        bus_write(A_CTRL, {8'h00, 4'($urandom_range(0, 4)), 4'h1});
      end else begin
        if ($urandom_range(0, 2) == 0) diff_in = 8'($urandom);
        tick();
      end
      nvec++; if (diff_in_debounced !== m_deb) begin nerr++; $display("FAIL deb_random got=%h exp=%h cyc=%0d", diff_in_debounced, m_deb, cyc); end
      nvec++; if (event_irq !== m_irq) begin nerr++; $display("FAIL irq_random got=%b exp=%b cyc=%0d", event_irq, m_irq, cyc); end
    end
  endtask

  task automatic test_disable();
    logic [7:0] frozen;
    int found = 0;
    bus_write(A_PER, 16'd5);
    bus_write(A_CTRL, 16'h0021);
    for (int k = 0; k < 30 && found == 0; k++) begin tick(); if (strobe_q) found = 1; end
    nvec++; if (found !== 1) begin nerr++; $display("FAIL dis_wait got=%0d exp=1", found); end
    tick(); tick();
    frozen = diff_in_debounced;
    bus_write(A_CTRL, 16'h0000);
    for (int k = 0; k < 30; k++) begin
      diff_in = 8'($urandom);
      tick();
      nvec++; if (strobe_q !== 1'b0) begin nerr++; $display("FAIL dis_strobe got=%b exp=0", strobe_q); end
      nvec++; if (diff_in_debounced !== frozen) begin nerr++; $display("FAIL dis_frozen got=%h exp=%h", diff_in_debounced, frozen); end
    end
  endtask

  task automatic test_readback();
    logic [15:0] p;
    logic [7:0] a;
    bus_write(A_PER, 16'd0);
    bus_write(A_CTRL, 16'h0011);
    diff_in = 8'hA5;
    repeat (10) tick();
    bus_write(A_CTRL, 16'h0010);
    nvec++; if (diff_in_debounced !== 8'hA5) begin nerr++; $display("FAIL rb_state got=%h exp=a5", diff_in_debounced); end
    bus_read(A_ST);
    nvec++; if (db_out_DISC !== 16'h00A5) begin nerr++; $display("FAIL rb_state_dout got=%h exp=00a5", db_out_DISC); end
    nvec++; if (data_from_DISC_avail !== 1'b1) begin nerr++; $display("FAIL rb_state_avail got=%b exp=1", data_from_DISC_avail); end
    bus_read(8'h00);
    nvec++; if (db_out_DISC !== 16'hFFFF) begin nerr++; $display("FAIL rb_miss_dout got=%h exp=ffff", db_out_DISC); end
    nvec++; if (data_from_DISC_avail !== 1'b0) begin nerr++; $display("FAIL rb_miss_avail got=%b exp=0", data_from_DISC_avail); end
    ab = A_ST;
    repeat (3) tick();
    nvec++; if (db_out_DISC !== 16'hFFFF || data_from_DISC_avail !== 1'b0) begin
      nerr++; $display("FAIL rb_hold got=%h/%b exp=ffff/0", db_out_DISC, data_from_DISC_avail);
    end
    bus_write(A_ST, 16'h1234);
    bus_read(A_ST);
    nvec++; if (db_out_DISC !== 16'h00A5) begin nerr++; $display("FAIL rb_state_ro got=%h exp=00a5", db_out_DISC); end
    bus_write(A_CTRL, 16'hFFF0);
    bus_read(A_CTRL);
    nvec++; if (db_out_DISC !== 16'h00F0) begin nerr++; $display("FAIL rb_ctrl got=%h exp=00f0", db_out_DISC); end
    p = 16'($urandom);
    bus_write(A_PER, p);
    bus_read(A_PER);
    nvec++; if (db_out_DISC !== p) begin nerr++; $display("FAIL rb_period got=%h exp=%h", db_out_DISC, p); end
    for (int k = 0; k < 8; k++) begin
      a = ($urandom_range(0, 5) < 4) ? 8'(A_CTRL + 8'($urandom_range(0, 3))) : 8'($urandom);
      bus_read(a);
      nvec++; if (db_out_DISC !== m_dout || data_from_DISC_avail !== m_avail) begin
        nerr++; $display("FAIL rb_random ab=%h got=%h/%b exp=%h/%b", a, db_out_DISC, data_from_DISC_avail, m_dout, m_avail);
      end
    end
  endtask

  task automatic test_events();
    bus_write(A_PER, 16'd0);
    bus_write(A_CTRL, 16'h0011);
`ifdef DIFI_EDGE_EVENT_EN
    diff_in = 8'h00;
    repeat (6) tick();
    bus_write(A_EV, 16'hFFFF);
    tick();
    bus_read(A_EV);
    nvec++; if (db_out_DISC !== 16'h0000) begin nerr++; $display("FAIL ev_clear_all got=%h exp=0000", db_out_DISC); end
    diff_in = 8'h01;
    repeat (6) tick();
    bus_read(A_EV);
    nvec++; if (db_out_DISC !== 16'h0100) begin nerr++; $display("FAIL ev_rise got=%h exp=0100", db_out_DISC); end
    nvec++; if (event_irq !== 1'b1) begin nerr++; $display("FAIL ev_irq_set got=%b exp=1", event_irq); end
    bus_write(A_EV, 16'h0100);
    tick();
    bus_read(A_EV);
    nvec++; if (db_out_DISC !== 16'h0000) begin nerr++; $display("FAIL ev_w1c got=%h exp=0000", db_out_DISC); end
    nvec++; if (event_irq !== 1'b0) begin nerr++; $display("FAIL ev_irq_clr got=%b exp=0", event_irq); end
    diff_in = 8'h00;
    repeat (6) tick();
    bus_write(A_EV, 16'hFFFF);
    tick();
    diff_in = 8'h01;
    tick(); tick();
    bus_write(A_EV, 16'h0100);
    bus_read(A_EV);
    nvec++; if (db_out_DISC !== 16'h0100) begin nerr++; $display("FAIL ev_set_wins got=%h exp=0100", db_out_DISC); end
    nvec++; if (event_irq !== 1'b1) begin nerr++; $display("FAIL ev_set_wins_irq got=%b exp=1", event_irq); end
    nvec++; if (db_out_DISC !== m_dout) begin nerr++; $display("FAIL ev_model got=%h exp=%h", db_out_DISC, m_dout); end
`else
    bus_read(A_EV);
    nvec++; if (db_out_DISC !== 16'h0000) begin nerr++; $display("FAIL ev_off_dout got=%h exp=0000", db_out_DISC); end
    nvec++; if (data_from_DISC_avail !== 1'b1) begin nerr++; $display("FAIL ev_off_avail got=%b exp=1", data_from_DISC_avail); end
    bus_write(A_EV, 16'hFFFF);
    for (int k = 0; k < 12; k++) begin
      diff_in = ~diff_in;
      tick();
      nvec++; if (event_irq !== 1'b0) begin nerr++; $display("FAIL ev_off_irq got=%b exp=0", event_irq); end
    end
`endif
  endtask

  task automatic test_reset_midcount();
    int found = 0;
    int ns = 0;
    bus_write(A_PER, 16'd6);
    bus_write(A_CTRL, 16'h0011);
    for (int k = 0; k < 40 && found == 0; k++) begin
      diff_in = 8'($urandom);
      tick();
      if (strobe_q && k > 10) found = 1;
    end
    nvec++; if (found !== 1) begin nerr++; $display("FAIL rst_mid_wait got=%0d exp=1", found); end
    tick(); tick();
    reset = 1'b0; write_qualified = 1'b1; read_qualified = 1'b1; ab = A_CTRL; db_in = 16'h0011;
    tick();
    reset = 1'b1; write_qualified = 1'b0; read_qualified = 1'b0;
    nvec++; if (db_out_DISC !== 16'h0000) begin nerr++; $display("FAIL rst_mid_dout got=%h exp=0000", db_out_DISC); end
    nvec++; if (data_from_DISC_avail !== 1'b0) begin nerr++; $display("FAIL rst_mid_avail got=%b exp=0", data_from_DISC_avail); end
    nvec++; if (diff_in_debounced !== 8'h00) begin nerr++; $display("FAIL rst_mid_deb got=%h exp=00", diff_in_debounced); end
    nvec++; if (sample_strobe !== 1'b0) begin nerr++; $display("FAIL rst_mid_strobe got=%b exp=0", sample_strobe); end
    nvec++; if (event_irq !== 1'b0) begin nerr++; $display("FAIL rst_mid_irq got=%b exp=0", event_irq); end
    for (int k = 0; k < 30; k++) begin tick(); if (strobe_q) ns++; end
    nvec++; if (ns !== 0) begin nerr++; $display("FAIL rst_mid_idle got=%0d strobes exp=0", ns); end
    bus_read(A_CTRL);
    nvec++; if (db_out_DISC !== 16'h0000) begin nerr++; $display("FAIL rst_mid_ctrl got=%h exp=0000", db_out_DISC); end
    bus_write(A_CTRL, 16'h0011);
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin tick(); if (strobe_q) found = 1; end
    nvec++; if (found !== 1) begin nerr++; $display("FAIL rst_mid_resume got=%0d exp=1", found); end
  endtask

  initial begin
    test_reset();
    test_period();
    test_debounce();
    test_disable();
    test_readback();
    test_events();
    test_reset_midcount();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/diff_in_scan_ctrl.md
DIFF_IN_SCAN_CTRL -- requirements
Module: diff_in_scan_ctrl

Interface
REQ-001 SHALL have parameter ADDR_CTRL, default 8'h60: bus address of the control register (R/W).
REQ-002 SHALL have parameter ADDR_PERIOD, default 8'h61: bus address of the sample-period register (R/W).
REQ-003 SHALL have parameter ADDR_STATE, default 8'h62: bus address of the debounced-state readback (R).
REQ-004 SHALL have parameter ADDR_EVENT, default 8'h63: bus address of the edge-event register (R, write-1-to-clear).
REQ-005 SHALL have port xclk, input, 1: sole clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-low reset.
REQ-007 SHALL have port write_qualified, input, 1: bus write strobe, one cycle per write.
REQ-008 SHALL have port read_qualified, input, 1: bus read strobe.
REQ-009 SHALL have port ab, input, 8: address bus.
REQ-010 SHALL have port db_in, input, 16: write data bus.
REQ-011 SHALL have port diff_in, input, 8: asynchronous differential-receiver inputs.
REQ-012 SHALL have port db_out_DISC, output, 16: registered read data.
REQ-013 SHALL have port data_from_DISC_avail, output, 1: high when db_out_DISC holds a valid read from this block.
REQ-014 SHALL have port diff_in_debounced, output, 8: debounced channel states.
REQ-015 SHALL have port sample_strobe, output, 1: one-cycle pulse at each scheduled sample.
REQ-016 SHALL have port event_irq, output, 1: edge-event attention flag.

Function
REQ-017 SHALL pass diff_in through a two-flop synchronizer that runs every cycle, independent of the FSM state.
REQ-018 SHALL define the control register as: bit0 EN; bits[7:4] DB_CNT (required consecutive samples, 0 treated as 1); other bits read 0.
REQ-019 SHALL define PERIOD as 16 bits; consecutive samples are spaced exactly PERIOD+1 xclk cycles apart, including PERIOD=0.
REQ-020 SHALL implement FSM states IDLE, COUNT, SAMPLE, with transitions: IDLE->COUNT when EN=1 (prescaler loaded with PERIOD); COUNT decrements, ->SAMPLE at 0; SAMPLE->COUNT next cycle, reloading PERIOD; any state->IDLE the cycle after EN is written 0.
REQ-021 SHALL assert sample_strobe for exactly the one cycle spent in SAMPLE, and never in IDLE.
REQ-022 SHALL, on each sample for each channel independently: if synchronized input equals debounced value, clear that channel's 4-bit counter; else increment it, and when the incremented value reaches DB_CNT, update diff_in_debounced to the new value and clear the counter.
REQ-023 SHALL apply debounced updates on the cycle after sample_strobe asserts (sample-to-output latency one cycle).
REQ-024 SHALL make PERIOD writes take effect at the next reload only; a DB_CNT write takes effect at the next sample; per-channel counters are preserved across such writes.
REQ-025 SHALL hold diff_in_debounced and per-channel counters frozen while in IDLE.
REQ-026 SHALL accept writes on write_qualified with matching ab; writes to ADDR_STATE or unmatched addresses SHALL be ignored.
REQ-027 SHALL, on read_qualified, register the addressed data into db_out_DISC with avail=1 on the next edge; unmatched ab SHALL give 16'hFFFF with avail=0; with read_qualified low both outputs SHALL hold.
REQ-028 SHALL return {8'h00, diff_in_debounced} for ADDR_STATE and {rise[7:0], fall[7:0]} for ADDR_EVENT.

Reset
REQ-029 SHALL, while reset is low at a rising xclk edge, clear: EN, DB_CNT, PERIOD, prescaler, counters, synchronizer, diff_in_debounced, events, db_out_DISC, data_from_DISC_avail, sample_strobe and event_irq; FSM goes to IDLE.
REQ-030 SHALL have reset override any simultaneous bus write, bus read or sample.
REQ-031 SHALL, for reset asserted mid-COUNT, discard the partial interval; after release the block stays in IDLE until EN is written 1.

Configuration
REQ-032 SHALL compile in the edge-event feature when the macro DIFI_EDGE_EVENT_EN is defined: a per-channel rise/fall bit sets on every debounced transition in that direction, ADDR_EVENT writes clear the bits written 1 in the matching positions of db_in, set wins over a same-cycle clear, and event_irq is the registered OR of all 16 bits.
REQ-033 SHALL, without DIFI_EDGE_EVENT_EN, tie event_irq to 0, return 16'h0000 with avail=1 for ADDR_EVENT reads, and ignore ADDR_EVENT writes.

Verification
REQ-034 SHALL cover: PERIOD=4, CTRL=16'h0011 -> sample_strobe every 5 cycles; PERIOD=0 -> strobe every cycle.
REQ-035 SHALL cover: DB_CNT=3, diff_in[2] 0->1 held -> diff_in_debounced=8'h04 one cycle after the third strobe; pulse lasting 2 samples -> no change.
REQ-036 SHALL cover: CTRL=16'h0000 written mid-COUNT -> IDLE next cycle, no further strobes, diff_in_debounced frozen.
REQ-037 SHALL cover: read ADDR_STATE with state 8'hA5 -> db_out_DISC=16'h00A5, avail=1; read ab=8'h00 -> 16'hFFFF, avail=0.
REQ-038 SHALL cover (macro defined): channel 0 rises -> event read 16'h0100, event_irq=1; write 16'h0100 to ADDR_EVENT -> 16'h0000, event_irq=0; same-cycle rise and clear -> bit stays 1.
REQ-039 SHALL cover: reset low during COUNT with pending events -> all outputs 0, no strobe until EN rewritten.
